// File: rtl/instr_imm_packer.sv
// instr_imm_packer: streaming RV32I immediate encoder for building
// instruction memory images. Each accepted word has its I/S/B immediate
// scattered into place, is range/alignment checked, and is emitted with a
// word address. Errored words are replaced by a NOP and flagged.
module instr_imm_packer #(
  parameter int                 ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_imm,
  input  logic [1:0]        in_immsrc,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count,
  output logic              done
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                out_valid_q;
  logic [31:0]         out_instr_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [ADDR_W-1:0]   next_addr_q;
  logic                out_err_q;
  logic [7:0]          err_count_q;
  logic                done_q;

  logic                accept;
  logic                out_fire;
  logic                i_ok;
  logic                b_ok;
  logic [31:0]         enc_instr_d;
  logic                enc_err_d;

  // The output register can take a new word whenever it is empty or being drained.
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // I/S immediates must fit in 12 signed bits; B needs 13 signed bits and even.
  assign i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];

  // Scatter the immediate into the instruction and flag out-of-range values.
  always_comb begin
    enc_instr_d = in_instr;
    enc_err_d   = 1'b0;
    case (in_immsrc)
      2'b00: begin
        enc_instr_d[31:20] = in_imm[11:0];
        enc_err_d          = ~i_ok;
      end
      2'b01: begin
        enc_instr_d[31:25] = in_imm[11:5];
        enc_instr_d[11:7]  = in_imm[4:0];
        enc_err_d          = ~i_ok;
      end
      2'b10: begin
        enc_instr_d[31]    = in_imm[12];
        enc_instr_d[30:25] = in_imm[10:5];
        enc_instr_d[11:8]  = in_imm[4:1];
        enc_instr_d[7]     = in_imm[11];
        enc_err_d          = ~b_ok;
      end
      default: begin
        enc_err_d = 1'b1;
      end
    endcase
    if (enc_err_d) begin
      enc_instr_d = NOP_INSTR;
    end
  end

  // Session FSM, output register, address counter and error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        out_valid_q <= 1'b1;
        out_instr_q <= enc_instr_d;
        out_err_q   <= enc_err_d;
        out_addr_q  <= next_addr_q;
        next_addr_q <= next_addr_q + ADDR_W'(1);
        if (enc_err_d && (err_count_q != 8'hFF)) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RUN;
            err_count_q <= '0;
            next_addr_q <= BASE_ADDR;
          end
        end
        S_RUN: begin
          if (accept && in_last) begin
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (out_fire) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_instr_imm_packer.sv
// Testbench for instr_imm_packer: directed steps plus randomized words,
// checked against an arithmetic reference model and a decode round trip.
module tb_instr_imm_packer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, out_ready;
  logic [31:0] in_instr, in_imm;
  logic [1:0]  in_immsrc;

  logic        in_ready, out_valid, out_err, done;
  logic [31:0] out_instr;
  logic [7:0]  out_addr, err_count;

  logic        in_ready2, out_valid2, out_err2, done2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_count2;

  instr_imm_packer #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm(in_imm), .in_immsrc(in_immsrc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count), .done(done)
  );

  instr_imm_packer #(.ADDR_W(2), .BASE_ADDR(2'd3)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_imm(in_imm), .in_immsrc(in_immsrc), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_err(out_err2), .err_count(err_count2), .done(done2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          addr;
    int          addr2;
    logic        err;
    logic [31:0] imm;
    logic [1:0]  src;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   m_idx;
  int   m_errcnt;
  int   last_waits;
  bit   rand_ready = 1'b0;

  `define CHK(tag, obs, expv) begin n_vec++; assert ((obs) === (expv)) else begin n_miss++; $error("FAIL %s: observed %0h expected %0h", tag, obs, expv); end end

  // Reference encoder: range rules as integer arithmetic, fields via masks/shifts.
  function automatic void model(input logic [31:0] instr, input logic [31:0] imm,
                                input logic [1:0] src, output logic [31:0] o, output logic e);
    int v;
    v = $signed(imm);
    o = 32'h0;
    case (src)
      2'd0: begin
        e = !(v >= -2048 && v <= 2047);
        o = (instr & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
      end
      2'd1: begin
        e = !(v >= -2048 && v <= 2047);
        o = (instr & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      2'd2: begin
        e = !(v >= -4096 && v <= 4094 && (v % 2) == 0);
        o = (instr & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      end
      default: e = 1'b1;
    endcase
    if (e) o = 32'h0000_0013;
  endfunction

  // Decode-side immediate extension, used for the round-trip check.
  function automatic logic [31:0] decode(input logic [31:0] x, input logic [1:0] s);
    case (s)
      2'd0:    return {{20{x[31]}}, x[31:20]};
      2'd1:    return {{20{x[31]}}, x[31:25], x[11:7]};
      default: return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
    endcase
  endfunction

  // One clock: score the output handshake, model the input acceptance, advance.
  task automatic cycle();
    exp_t e;
    logic [31:0] o;
    logic er;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        `CHK("unexpected_output", out_valid, 1'b0)
      end else begin
        e = exp_q.pop_front();
        `CHK("out_instr", out_instr, e.instr)
        `CHK("out_err", out_err, e.err)
        `CHK("out_addr", out_addr, e.addr[7:0])
        `CHK("out_addr_w2", out_addr2, e.addr2[1:0])
        `CHK("out_instr_w2", out_instr2, e.instr)
        if (!e.err) begin
          `CHK("roundtrip", decode(out_instr, e.src), e.imm)
        end
        $display("word addr=%0d instr=%08h err=%0b", out_addr, out_instr, out_err);
      end
    end
    if (in_valid && in_ready) begin
      model(in_instr, in_imm, in_immsrc, o, er);
      e.instr = o; e.err = er; e.imm = in_imm; e.src = in_immsrc;
      e.addr  = m_idx % 256;
      e.addr2 = (3 + m_idx) % 4;
      exp_q.push_back(e);
      m_idx++;
      if (er && m_errcnt < 255) m_errcnt++;
    end
    @(posedge clk);
    #1;
    `CHK("out_valid", out_valid, (exp_q.size() != 0))
    `CHK("err_count", err_count, m_errcnt[7:0])
    if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
    end
  endtask

  task automatic start_session();
    m_idx = 0;
    m_errcnt = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] imm,
                      input logic [1:0] src, input logic last);
    int budget;
    in_instr = instr; in_imm = imm; in_immsrc = src; in_last = last; in_valid = 1'b1;
    #1;
    budget = 0;
    while (!in_ready && budget < 50) begin
      cycle();
      budget++;
    end
    last_waits = budget;
    if (budget >= 50) begin
      `CHK("in_ready_timeout", in_ready, 1'b1)
    end
    cycle();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    #1;
    for (k = 0; k < 30; k++) begin
      cycle();
      if (done) break;
    end
    `CHK("done_seen", done, 1'b1)
    `CHK("done_w2", done2, 1'b1)
    `CHK("queue_drained", exp_q.size(), 0)
    cycle();
    `CHK("done_one_cycle", done, 1'b0)
    `CHK("idle_in_ready", in_ready, 1'b0)
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sv_instr;
    logic [7:0]  sv_addr;
    logic        sv_err;
    int          n;
    int          pick;
    logic [31:0] imm_r;
    int          bnd [10];
    bnd = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4097, -4098, 0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_imm = '0; in_immsrc = '0;
    m_idx = 0; m_errcnt = 0;
    #1;
    `CHK("rst_out_valid", out_valid, 1'b0)
    `CHK("rst_out_instr", out_instr, 32'h0)
    `CHK("rst_out_addr", out_addr, 8'd0)
    `CHK("rst_out_addr_w2", out_addr2, 2'd3)
    `CHK("rst_out_err", out_err, 1'b0)
    `CHK("rst_err_count", err_count, 8'd0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_in_ready", in_ready, 1'b0)
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // I-type single word session
    out_ready = 1'b1;
    start_session();
    send(32'h0000_0093, 32'hFFFF_FFFF, 2'b00, 1'b1);
    `CHK("t1_instr", out_instr, 32'hFFF0_0093)
    `CHK("t1_addr", out_addr, 8'd0)
    `CHK("t1_err", out_err, 1'b0)
    `CHK("t1_no_early_done", done, 1'b0)
    cycle();
    `CHK("t1_done", done, 1'b1)
    cycle();
    `CHK("t1_done_end", done, 1'b0)

    // S, B and error words
    start_session();
    send(32'h0020_2023, 32'hFFFF_F808, 2'b01, 1'b0);
    `CHK("s_instr", out_instr, 32'h8020_2423)
    `CHK("s_err", out_err, 1'b0)
    send(32'h0000_0063, 32'h0000_0010, 2'b10, 1'b0);
    `CHK("b_instr", out_instr, 32'h0000_0863)
    send(32'h0000_0063, 32'h0000_0011, 2'b10, 1'b0);
    `CHK("b_odd_instr", out_instr, 32'h0000_0013)
    `CHK("b_odd_err", out_err, 1'b1)
    `CHK("b_odd_cnt", err_count, 8'd1)
    send(32'h0000_0093, 32'h0000_0800, 2'b00, 1'b0);
    `CHK("i_range_err", out_err, 1'b1)
    `CHK("i_range_cnt", err_count, 8'd2)
    send(32'h0000_0093, 32'h0000_0001, 2'b11, 1'b1);
    `CHK("illegal_err", out_err, 1'b1)
    `CHK("illegal_cnt", err_count, 8'd3)
    wait_done();

    // Backpressure: stall 3 cycles after the first word, then full rate
    start_session();
    send(32'h0000_0013, 32'h0000_0001, 2'b00, 1'b0);
    out_ready = 1'b0;
    in_instr = 32'h0000_0013; in_imm = 32'h2; in_immsrc = 2'b00; in_last = 1'b0; in_valid = 1'b1;
    #1;
    sv_instr = out_instr; sv_addr = out_addr; sv_err = out_err;
    for (int s = 0; s < 3; s++) begin
      `CHK("stall_in_ready", in_ready, 1'b0)
      cycle();
      `CHK("stall_instr", out_instr, sv_instr)
      `CHK("stall_addr", out_addr, sv_addr)
      `CHK("stall_err", out_err, sv_err)
    end
    out_ready = 1'b1;
    for (int w = 1; w < 4; w++) begin
      send(32'h0000_0013, 32'(w + 1), 2'b00, (w == 3));
      `CHK("throughput_waits", last_waits, 0)
    end
    wait_done();

    // Randomized sessions with random backpressure
    for (int sess = 0; sess < 4; sess++) begin
      start_session();
      rand_ready = 1'b1;
      n = $urandom_range(10, 40);
      for (int w = 0; w < n; w++) begin
        pick = $urandom_range(0, 3);
        case (pick)
          0:       imm_r = $urandom;
          1:       imm_r = 32'($urandom_range(0, 8191)) - 32'd4096;
          2:       imm_r = 32'(bnd[$urandom_range(0, 9)]);
          default: imm_r = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
        endcase
        send($urandom, imm_r, 2'($urandom_range(0, 3)), (w == n - 1));
      end
      wait_done();
    end

    // Error counter saturation
    start_session();
    for (int w = 0; w < 300; w++) begin
      send($urandom, $urandom, 2'b11, (w == 299));
    end
    `CHK("sat_cnt", err_count, 8'd255)
    wait_done();

    // New session clears the counter; narrow instance address wraps 3,0,1
    start_session();
    `CHK("start_clears_cnt", err_count, 8'd0)
    send(32'h0000_0093, 32'h5, 2'b00, 1'b0);
    `CHK("wrap_addr0", out_addr2, 2'd3)
    send(32'h0000_0093, 32'h6, 2'b00, 1'b0);
    `CHK("wrap_addr1", out_addr2, 2'd0)
    send(32'h0000_0093, 32'h7, 2'b00, 1'b1);
    `CHK("wrap_addr2", out_addr2, 2'd1)
    wait_done();

    // Asynchronous reset mid-session with a pending output
    start_session();
    out_ready = 1'b0;
    send(32'h0000_0063, 32'h11, 2'b10, 1'b0);
    `CHK("pre_rst_valid", out_valid, 1'b1)
    `CHK("pre_rst_cnt", err_count, 8'd1)
    #2 rst = 1'b1;
    #1;
    `CHK("arst_valid", out_valid, 1'b0)
    `CHK("arst_cnt", err_count, 8'd0)
    `CHK("arst_instr", out_instr, 32'h0)
    `CHK("arst_addr", out_addr, 8'd0)
    `CHK("arst_err", out_err, 1'b0)
    `CHK("arst_done", done, 1'b0)
    exp_q.delete();
    m_errcnt = 0;
    #3 rst = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      `CHK("post_rst_no_done", done, 1'b0)
      `CHK("post_rst_idle", in_ready, 1'b0)
    end
    start_session();
    send(32'h0000_0093, 32'hFFFF_F800, 2'b00, 1'b1);
    `CHK("post_rst_addr", out_addr, 8'd0)
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
